// File: rtl/prog_mem_arbiter.sv
// Shares the single program-memory request/ack port between instruction fetch (F)
// and an auxiliary read port (D): one outstanding access, round-robin, ack timeout.
module prog_mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_f_req,
    input  logic [31:0] i_f_addr,
    output logic        or_f_valid,
    output logic [31:0] or_f_data,
    output logic        or_f_err,
    input  logic        i_d_req,
    input  logic [31:0] i_d_addr,
    output logic        or_d_valid,
    output logic [31:0] or_d_data,
    output logic        or_d_err,
    output logic        or_mem_req,
    output logic [31:0] or_mem_addr,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_ack,
    output logic        or_busy
);

    localparam logic       PORT_F   = 1'b0;
    localparam logic       PORT_D   = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_reg, state_next;
    logic        owner_reg, owner_next;
    logic        last_grant_reg, last_grant_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        err_reg, err_next;
    logic [31:0] addr_reg, addr_next;
    logic        capture;
    logic [31:0] capture_data;
    logic        grant_d;
    logic [1:0]  port_valid;
    logic [1:0]  port_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= PORT_F;
            last_grant_reg <= PORT_D;
            cnt_reg        <= 8'h00;
            err_reg        <= 1'b0;
            addr_reg       <= 32'h0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            cnt_reg        <= cnt_next;
            err_reg        <= err_next;
            addr_reg       <= addr_next;
        end
    end

    // On a tie the port that did not win last time is granted.
    always_comb begin
        if (i_f_req && i_d_req) begin
            grant_d = ~last_grant_reg;
        end else begin
            grant_d = i_d_req;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        cnt_next        = cnt_reg;
        err_next        = err_reg;
        addr_next       = addr_reg;
        capture         = 1'b0;
        capture_data    = 32'h0;
        case (state_reg)
            ST_IDLE: begin
                if (i_f_req || i_d_req) begin
                    owner_next = grant_d;
                    addr_next  = grant_d ? i_d_addr : i_f_addr;
                    cnt_next   = 8'h00;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Ack wins over a timeout expiring in the same cycle.
                if (i_mem_ack) begin
                    capture      = 1'b1;
                    capture_data = i_mem_data;
                    err_next     = 1'b0;
                    state_next   = ST_RESP;
                end else if (cnt_reg >= CNT_LAST) begin
                    capture      = 1'b1;
                    capture_data = 32'h0;
                    err_next     = 1'b1;
                    state_next   = ST_RESP;
                end else if (cnt_reg != 8'hFF) begin
                    cnt_next = cnt_reg + 8'h01;
                end
            end
            ST_RESP: begin
                last_grant_next = owner_reg;
                state_next      = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Per-port result register and completion decode; index 0 is F, 1 is D.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [31:0] data_reg;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                data_reg <= 32'h0;
            end else if (capture && (owner_reg == 1'(gi))) begin
                data_reg <= capture_data;
            end
        end

        assign port_valid[gi] = (state_reg == ST_RESP) && (owner_reg == 1'(gi));
        assign port_err[gi]   = port_valid[gi] && err_reg;
    end

    assign or_f_valid  = port_valid[0];
    assign or_f_err    = port_err[0];
    assign or_f_data   = g_port[0].data_reg;
    assign or_d_valid  = port_valid[1];
    assign or_d_err    = port_err[1];
    assign or_d_data   = g_port[1].data_reg;
    assign or_mem_req  = (state_reg == ST_WAIT);
    assign or_mem_addr = addr_reg;
    assign or_busy     = (state_reg != ST_IDLE);

endmodule
